// File: rtl/sccb_target.sv
// SCCB responder: camera-side end of SIOC/SIOD.
// Decodes 3-phase writes and serves 2-phase reads.
module sccb_target #(
  parameter logic [7:0] DEV_ID    = 8'h42,
  parameter bit         DRIVE_ACK = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sioc,
  input  logic       i_siod,
  output logic       o_siod_oe,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  typedef enum logic [3:0] {
    IDLE, ID, ACK_ID, SUB, ACK_SUB,
    DATA, ACK_DATA, RDATA, RD_NA, WAIT_STOP
  } state_t;

  logic [1:0] sioc_sy, siod_sy;
  logic       sioc_d, siod_d;
  logic       rise, fall, start, stop;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n;
  logic [7:0] sub, sub_n;
  logic [7:0] wr_data, wr_data_n;
  logic       rw, rw_n;
  logic       ack_on, ack_on_n;
  logic       oe, oe_n;
  logic       wr_en, wr_en_n;
  logic       err, err_n;
  logic       partial;
  logic [7:0] byte_in;

  // Lines idle high, so sync stages reset high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sioc_sy <= 2'b11;
      siod_sy <= 2'b11;
      sioc_d  <= 1'b1;
      siod_d  <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      start   <= 1'b0;
      stop    <= 1'b0;
    end else begin
      sioc_sy <= {sioc_sy[0], i_sioc};
      siod_sy <= {siod_sy[0], i_siod};
      sioc_d  <= sioc_sy[1];
      siod_d  <= siod_sy[1];
      rise    <= sioc_sy[1] & ~sioc_d;
      fall    <= ~sioc_sy[1] & sioc_d;
      start   <= sioc_sy[1] & sioc_d
               & siod_d & ~siod_sy[1];
      stop    <= sioc_sy[1] & sioc_d
               & ~siod_d & siod_sy[1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      sub     <= '0;
      wr_data <= '0;
      rw      <= 1'b0;
      ack_on  <= 1'b0;
      oe      <= 1'b0;
      wr_en   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sr      <= sr_n;
      sub     <= sub_n;
      wr_data <= wr_data_n;
      rw      <= rw_n;
      ack_on  <= ack_on_n;
      oe      <= oe_n;
      wr_en   <= wr_en_n;
      err     <= err_n;
    end
  end

  // siod_d is the data level captured with the rise.
  assign byte_in = {sr[6:0], siod_d};

  // START/STOP framing always costs one SIOC rise,
  // so a single sampled bit is not an aborted byte.
  assign partial = (state == ID || state == SUB
                 || state == DATA) && cnt > 4'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sr_n      = sr;
    sub_n     = sub;
    wr_data_n = wr_data;
    rw_n      = rw;
    ack_on_n  = ack_on;
    oe_n      = oe;
    wr_en_n   = 1'b0;
    err_n     = 1'b0;
    unique case (1'b1)
      stop: begin
        state_n  = IDLE;
        cnt_n    = '0;
        ack_on_n = 1'b0;
        oe_n     = 1'b0;
        err_n    = partial;
      end
      start: begin
        state_n  = ID;
        cnt_n    = '0;
        ack_on_n = 1'b0;
        oe_n     = 1'b0;
        err_n    = partial;
      end
      default: begin
        unique case (state)
          ID: if (rise) begin
            sr_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = '0;
              if (byte_in == DEV_ID) begin
                state_n = ACK_ID;
                rw_n    = 1'b0;
              end else if (byte_in == RD_ID) begin
                state_n = ACK_ID;
                rw_n    = 1'b1;
              end else begin
                state_n = WAIT_STOP;
                err_n   = 1'b1;
              end
            end
          end
          ACK_ID, ACK_SUB, ACK_DATA: if (fall) begin
            if (!ack_on) begin
              ack_on_n = 1'b1;
              oe_n     = DRIVE_ACK;
            end else begin
              ack_on_n = 1'b0;
              oe_n     = 1'b0;
              cnt_n    = '0;
              unique case (state)
                ACK_ID: if (rw) begin
                  // Release fall is also bit 7 launch.
                  state_n = RDATA;
                  sr_n    = {i_rd_data[6:0], 1'b0};
                  oe_n    = ~i_rd_data[7];
                  cnt_n   = 4'd1;
                end else begin
                  state_n = SUB;
                end
                ACK_SUB: state_n = DATA;
                default: state_n = WAIT_STOP;
              endcase
            end
          end
          SUB: if (rise) begin
            sr_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n   = '0;
              sub_n   = byte_in;
              state_n = ACK_SUB;
            end
          end
          DATA: if (rise) begin
            sr_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n     = '0;
              wr_en_n   = 1'b1;
              wr_data_n = byte_in;
              state_n   = ACK_DATA;
            end
          end
          RDATA: if (fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              cnt_n   = '0;
              state_n = RD_NA;
            end else begin
              oe_n  = ~sr[7];
              sr_n  = {sr[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
          RD_NA: if (rise) state_n = WAIT_STOP;
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    o_busy    = (state != IDLE);
    o_siod_oe = oe;
    o_wr_en   = wr_en;
    o_wr_addr = sub;
    o_wr_data = wr_data;
    o_rd_addr = sub;
    o_err     = err;
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: write table,
// reads, aborts, repeated start and async reset.
module tb_sccb_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sioc = 1'b1;
  logic       m_low = 1'b0;

  logic       oe1, wr1, busy1, err1;
  logic [7:0] wa1, wd1, ra1, rd1;
  logic       oe0, wr0, busy0, err0;
  logic [7:0] wa0, wd0, ra0, rd0;
  logic       siod1, siod0;

  assign siod1 = ~(m_low | oe1);
  assign siod0 = ~(m_low | oe0);
  assign rd1   = ra1 ^ 8'h7C;
  assign rd0   = ra0 ^ 8'h7C;

  always #5 clk = ~clk;

  sccb_target #(.DEV_ID(8'h42), .DRIVE_ACK(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_sioc(sioc),
    .i_siod(siod1), .o_siod_oe(oe1), .o_wr_en(wr1),
    .o_wr_addr(wa1), .o_wr_data(wd1), .o_rd_addr(ra1),
    .i_rd_data(rd1), .o_busy(busy1), .o_err(err1)
  );

  sccb_target #(.DEV_ID(8'h42), .DRIVE_ACK(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sioc(sioc),
    .i_siod(siod0), .o_siod_oe(oe0), .o_wr_en(wr0),
    .o_wr_addr(wa0), .o_wr_data(wd0), .o_rd_addr(ra0),
    .i_rd_data(rd0), .o_busy(busy0), .o_err(err0)
  );

  int checks = 0;
  int fails  = 0;
  int wr_cnt = 0, err_cnt = 0, oe_cnt = 0;
  int oe0_cnt = 0, wr0_cnt = 0, long_cnt = 0;
  logic [7:0] la = 8'h00, ld = 8'h00;
  logic       wr_prev = 1'b0;

  always @(posedge clk) begin
    if (wr1) begin
      wr_cnt <= wr_cnt + 1;
      la     <= wa1;
      ld     <= wd1;
    end
    if (wr1 && wr_prev) long_cnt <= long_cnt + 1;
    wr_prev <= wr1;
    if (err1) err_cnt <= err_cnt + 1;
    if (oe1)  oe_cnt  <= oe_cnt + 1;
    if (oe0)  oe0_cnt <= oe0_cnt + 1;
    if (wr0)  wr0_cnt <= wr0_cnt + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_clk(Q); m_low = ~b;
    wait_clk(Q); sioc = 1'b1;
    wait_clk(Q); @(negedge clk); s = siod1;
    wait_clk(Q); sioc = 1'b0;
  endtask

  task automatic start_c();
    wait_clk(Q); m_low = 1'b0;
    wait_clk(Q); sioc = 1'b1;
    wait_clk(Q); m_low = 1'b1;
    wait_clk(Q); sioc = 1'b0;
  endtask

  task automatic stop_c();
    wait_clk(Q); m_low = 1'b1;
    wait_clk(Q); sioc = 1'b1;
    wait_clk(Q); m_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(1'b1, s);
  endtask

  task automatic xfer(input logic [7:0] id, sub, dat,
                      input int n,
                      output logic [2:0] acks,
                      output logic bmid, bend);
    logic a;
    acks = 3'b000;
    start_c();
    @(negedge clk); bmid = busy1;
    send_byte(id, a); acks[0] = a;
    if (n > 1) begin send_byte(sub, a); acks[1] = a; end
    if (n > 2) begin send_byte(dat, a); acks[2] = a; end
    stop_c();
    @(negedge clk); bend = busy1;
  endtask

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] dat;
    logic [1:0] n;
    logic [2:0] acks;
    logic [1:0] wr;
    logic [1:0] err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [2:0] acks;
    logic       bm, be, a;
    logic [7:0] d;
    int w0, e0, o0, z0, y0;

    tbl[0] = '{8'h42, 8'h12, 8'h80, 2'd3, 3'b111, 2'd1, 2'd0};
    tbl[1] = '{8'h60, 8'h11, 8'h22, 2'd2, 3'b000, 2'd0, 2'd1};
    tbl[2] = '{8'h42, 8'hFF, 8'h00, 2'd3, 3'b111, 2'd1, 2'd0};
    tbl[3] = '{8'h41, 8'h05, 8'hAA, 2'd3, 3'b000, 2'd0, 2'd1};

    wait_clk(4);
    @(negedge clk);
    chk("rst_oe", 32'(oe1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_out", {8'(wr1), 8'(err1), wa1, ra1}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt; e0 = err_cnt; o0 = oe_cnt;
      z0 = oe0_cnt; y0 = wr0_cnt;
      xfer(tbl[i].id, tbl[i].sub, tbl[i].dat,
           int'(tbl[i].n), acks, bm, be);
      chk($sformatf("v%0d_acks", i), 32'(acks),
          32'(tbl[i].acks));
      chk($sformatf("v%0d_wr", i), 32'(wr_cnt - w0),
          32'(tbl[i].wr));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0),
          32'(tbl[i].err));
      chk($sformatf("v%0d_busy", i), {bm, be}, 32'd2);
      chk($sformatf("v%0d_nack_oe", i),
          32'(oe0_cnt - z0), 32'd0);
      chk($sformatf("v%0d_wr0", i), 32'(wr0_cnt - y0),
          32'(tbl[i].wr));
      if (tbl[i].wr != 2'd0)
        chk($sformatf("v%0d_ad", i), {la, ld},
            {tbl[i].sub, tbl[i].dat});
      else
        chk($sformatf("v%0d_oe", i),
            32'(oe_cnt - o0), 32'd0);
    end

    // 2-phase write of sub-address, then read
    w0 = wr_cnt;
    start_c();
    send_byte(8'h42, a);
    send_byte(8'h0A, a);
    stop_c();
    chk("s2_rdaddr", 32'(ra1), 32'h0A);
    start_c();
    send_byte(8'h43, a);
    chk("s2_rdack", 32'(a), 32'd1);
    read_byte(d);
    stop_c();
    chk("s2_data", 32'(d), 32'h76);
    chk("s2_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("s2_busy", 32'(busy1), 32'd0);

    // STOP inside the data byte
    w0 = wr_cnt; e0 = err_cnt;
    start_c();
    send_byte(8'h42, a);
    send_byte(8'h20, a);
    clk_bit(1'b0, a); clk_bit(1'b1, a);
    clk_bit(1'b0, a); clk_bit(1'b1, a);
    stop_c();
    @(negedge clk);
    chk("s4_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("s4_err", 32'(err_cnt - e0), 32'd1);
    chk("s4_busy", 32'(busy1), 32'd0);
    w0 = wr_cnt;
    xfer(8'h42, 8'h20, 8'h55, 3, acks, bm, be);
    chk("s4_wr", 32'(wr_cnt - w0), 32'd1);
    chk("s4_ad", {la, ld}, {8'h20, 8'h55});

    // Repeated START after the sub-address ack
    w0 = wr_cnt;
    start_c();
    send_byte(8'h42, a);
    send_byte(8'h33, a);
    start_c();
    send_byte(8'h43, a);
    read_byte(d);
    stop_c();
    chk("s5_rdaddr", 32'(ra1), 32'h33);
    chk("s5_data", 32'(d), 32'h4F);
    chk("s5_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("s5_long", 32'(long_cnt), 32'd0);

    // Async reset in the middle of the ID ack
    start_c();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h42;
      clk_bit(d[i], a);
    end
    wait_clk(Q);
    chk("s6_oe_pre", 32'(oe1), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("s6_oe_rst", 32'(oe1), 32'd0);
    chk("s6_busy", 32'(busy1), 32'd0);
    chk("s6_out", {wa1, wd1, ra1, 7'd0, wr1 | err1},
        32'd0);
    sioc = 1'b1; m_low = 1'b0;
    wait_clk(4);
    @(negedge clk) rst = 1'b0;
    wait_clk(4);
    w0 = wr_cnt; z0 = oe0_cnt; y0 = wr0_cnt;
    xfer(8'h42, 8'h12, 8'h80, 3, acks, bm, be);
    chk("s6_acks", 32'(acks), 32'd7);
    chk("s6_wr", 32'(wr_cnt - w0), 32'd1);
    chk("s6_ad", {la, ld}, {8'h12, 8'h80});
    chk("s6_busy_frm", {bm, be}, 32'd2);
    chk("s6_nack_oe", 32'(oe0_cnt - z0), 32'd0);
    chk("s6_wr0", 32'(wr0_cnt - y0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
